// File: rtl/ball_sequencer.sv
// Per-frame ball controller: erase, step position, wait for direction logic, redraw.
// Optional build macro BALL_SEQ_PAUSE_EN adds a pause input that freezes frame counting.
module ball_sequencer #(
    parameter int X_MAX           = 160,
    parameter int Y_MAX           = 120,
    parameter int SIZE            = 4,
    parameter int X_INIT          = 78,
    parameter int Y_INIT          = 58,
    parameter int STEP            = 1,
    parameter int FRAMES_PER_MOVE = 2
) (
`ifdef BALL_SEQ_PAUSE_EN
    input  logic       pause,
`endif
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       x_du,
    input  logic       y_du,
    input  logic       plot_ack,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       plot_req,
    output logic       plot_erase,
    output logic       moved
);

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_ERASE   = 3'd2;
    localparam logic [2:0] S_MOVE    = 3'd3;
    localparam logic [2:0] S_SETTLE1 = 3'd4;
    localparam logic [2:0] S_SETTLE2 = 3'd5;
    localparam logic [2:0] S_DRAW    = 3'd6;

    localparam logic [7:0]  LAST_FRAME = 8'(FRAMES_PER_MOVE - 1);
    localparam logic [10:0] STEP_W     = 11'(STEP);
    localparam logic [10:0] X_LIM      = 11'(X_MAX - SIZE);
    localparam logic [10:0] Y_LIM      = 11'(Y_MAX - SIZE);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       pause_w;

`ifdef BALL_SEQ_PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    // Clamp to the wall exactly so the direction logic's equality compare always hits.
    function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic du,
                                             input logic [10:0] lim);
        logic [10:0] p;
        logic [10:0] up;
        p  = {1'b0, pos};
        up = p + STEP_W;
        if (du)
            return (up > lim) ? lim[9:0] : up[9:0];
        else
            return (p < STEP_W) ? 10'd0 : 10'(p - STEP_W);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            S_INIT:  state_d = S_DRAW;
            S_WAIT: begin
                if (frame_tick && !pause_w) begin
                    if (cnt_q == LAST_FRAME) begin
                        cnt_d   = 8'd0;
                        state_d = S_ERASE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_ERASE: if (plot_ack) state_d = S_MOVE;
            S_MOVE: begin
                x_d     = step_axis(x_q, x_du, X_LIM);
                y_d     = step_axis(y_q, y_du, Y_LIM);
                state_d = S_SETTLE1;
            end
            S_SETTLE1: state_d = S_SETTLE2;
            S_SETTLE2: state_d = S_DRAW;
            S_DRAW:  if (plot_ack) state_d = S_WAIT;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_INIT;
            cnt_q   <= 8'd0;
            x_q     <= 10'(X_INIT);
            y_q     <= 10'(Y_INIT);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign plot_req   = (state_q == S_ERASE) || (state_q == S_DRAW);
    assign plot_erase = (state_q == S_ERASE);
    assign moved      = (state_q == S_MOVE);

endmodule

// File: tb/tb_ball_sequencer.sv
// Randomized scoreboard bench for ball_sequencer: a frame/position model predicts every
// plot transaction, a separate monitor checks them as the plotter handshake completes.
module tb_ball_sequencer;

    localparam int X_MAX  = 160;
    localparam int Y_MAX  = 120;
    localparam int SIZE   = 4;
    localparam int X_INIT = 155;
    localparam int Y_INIT = 58;
    localparam int STEP   = 3;
    localparam int FPM    = 2;
    localparam int X_LIM  = X_MAX - SIZE;
    localparam int Y_LIM  = Y_MAX - SIZE;
    localparam int N_CYC  = 30000;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       frame_tick = 1'b0;
    logic       x_du = 1'b1;
    logic       y_du = 1'b1;
    logic       plot_ack = 1'b0;
    logic [9:0] x, y;
    logic       plot_req, plot_erase, moved;
`ifdef BALL_SEQ_PAUSE_EN
    logic       pause = 1'b0;
`endif

    always #5 clk = ~clk;

    ball_sequencer #(
        .X_MAX(X_MAX), .Y_MAX(Y_MAX), .SIZE(SIZE), .X_INIT(X_INIT), .Y_INIT(Y_INIT),
        .STEP(STEP), .FRAMES_PER_MOVE(FPM)
    ) dut (
`ifdef BALL_SEQ_PAUSE_EN
        .pause(pause),
`endif
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .x_du(x_du), .y_du(y_du),
        .plot_ack(plot_ack), .x(x), .y(y), .plot_req(plot_req), .plot_erase(plot_erase),
        .moved(moved)
    );

    typedef struct packed {
        logic       erase;
        logic [9:0] px;
        logic [9:0] py;
    } plot_t;

    plot_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    exp_moves = 0;
    int    mon_moves = 0;
    bit    mon_en = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation whenever a plot request is about to be accepted.
    initial begin
        int    since_erase;
        plot_t e;
        since_erase = -1;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (since_erase >= 0) since_erase++;
                if (since_erase >= 1 && since_erase <= 4) begin
                    check("moved_timing", int'(moved), int'(since_erase == 1));
                    if (since_erase == 4) begin
                        check("draw_after_settle", int'(plot_req && !plot_erase), 1);
                        since_erase = -1;
                    end
                end else begin
                    check("moved_stray", int'(moved), 0);
                end
                if (moved) mon_moves++;
                if (plot_req && plot_ack) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_plot", 1, int'(exp_q.size()));
                    end else begin
                        e = exp_q.pop_front();
                        check("plot_erase", int'(plot_erase), int'(e.erase));
                        check("plot_x", int'(x), int'(e.px));
                        check("plot_y", int'(y), int'(e.py));
                        $display("plot erase=%0d x=%0d y=%0d", plot_erase, x, y);
                    end
                    if (plot_erase) since_erase = 0;
                end
            end
        end
    end

    function automatic int step_pos(input int pos, input bit du, input int lim);
        if (du) return (pos + STEP > lim) ? lim : pos + STEP;
        return (pos < STEP) ? 0 : pos - STEP;
    endfunction

    function automatic int pick_stall();
        int r;
        r = int'($urandom % 8);
        if (r < 4) return 0;
        if (r < 6) return int'($urandom_range(1, 3));
        if (r == 6) return 20;
        return 5;
    endfunction

    initial begin
        int mx, my, frames, stall, nx, ny;
        bit model_idle, draining, draw_done, pause_m, found;
        mx = X_INIT; my = Y_INIT; frames = 0; stall = 0;
        model_idle = 1'b0;

        // Reset and initial draw
        plot_ack = 1'b1;
        exp_q.push_back('{1'b0, 10'(X_INIT), 10'(Y_INIT)});
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", int'(plot_req), 0);
        check("rst_erase", int'(plot_erase), 0);
        check("rst_moved", int'(moved), 0);
        check("rst_x", int'(x), X_INIT);
        check("rst_y", int'(y), Y_INIT);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("init_req_low", int'(plot_req), 0);
        @(negedge clk);
        check("first_draw_req", int'(plot_req), 1);
        check("first_draw_erase", int'(plot_erase), 0);
        @(posedge clk); #1;
        model_idle = 1'b1;

        for (int c = 0; c < N_CYC + 300; c++) begin
            draining = (c >= N_CYC);
            if (draining && model_idle) break;
            if (plot_req) begin
                plot_ack = (stall == 0);
                if (stall > 0) stall--;
            end else begin
                plot_ack = $urandom_range(0, 1) == 1;
            end
            draw_done = plot_req && plot_ack && !plot_erase;
            if (plot_req && plot_ack) stall = pick_stall();
            frame_tick = !draining && ($urandom % 4 == 0);
`ifdef BALL_SEQ_PAUSE_EN
            if (draining) pause = 1'b0;
            else if ($urandom % 40 == 0) pause = ~pause;
            pause_m = pause;
`else
            pause_m = 1'b0;
`endif
            if (frame_tick && model_idle && !pause_m) begin
                frames++;
                if (frames == FPM) begin
                    frames = 0;
                    if (mx >= X_LIM) x_du = 1'b0;
                    else if (mx == 0) x_du = 1'b1;
                    else if ($urandom % 8 == 0) x_du = ~x_du;
                    if (my >= Y_LIM) y_du = 1'b0;
                    else if (my == 0) y_du = 1'b1;
                    else if ($urandom % 8 == 0) y_du = ~y_du;
                    nx = step_pos(mx, x_du, X_LIM);
                    ny = step_pos(my, y_du, Y_LIM);
                    exp_q.push_back('{1'b1, 10'(mx), 10'(my)});
                    exp_q.push_back('{1'b0, 10'(nx), 10'(ny)});
                    mx = nx; my = ny;
                    exp_moves++;
                    model_idle = 1'b0;
                end
            end
            if (draw_done) model_idle = 1'b1;
            @(posedge clk); #1;
        end
        frame_tick = 1'b0;
        check("drain_idle", int'(model_idle), 1);
        @(negedge clk);
        check("move_count", mon_moves, exp_moves);
        check("queue_empty", exp_q.size(), 0);

        // Reset in the middle of a draw handshake
        @(posedge clk); #1;
        mon_en = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (plot_req && !plot_erase) begin
                found = 1'b1;
            end else begin
                plot_ack = plot_erase;
                frame_tick = 1'b1;
                @(posedge clk); #1;
            end
        end
        frame_tick = 1'b0;
        plot_ack = 1'b0;
        check("reach_draw", int'(found), 1);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("midrst_req", int'(plot_req), 0);
        check("midrst_x", int'(x), X_INIT);
        check("midrst_y", int'(y), Y_INIT);
        check("midrst_moved", int'(moved), 0);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("redraw_req", int'(plot_req), 1);
        check("redraw_erase", int'(plot_erase), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
